// File: rtl/tc_hdd_pkg.sv
// Shared types for the Hdd arbiter: controller states and the latched request record.
package tc_hdd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        port;
    logic        write;
    logic        err;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

endpackage

// File: rtl/tc_rr_arb2.sv
// Two-way round-robin grant, purely combinational; prio names the port that wins a tie.
module tc_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/tc_hdd_arbiter.sv
// Arbitrates two requesters onto one sequential-head Hdd; responses 1/2/3 cycles after acceptance
// (error / no seek / seek), one request in flight, no response backpressure.
module tc_hdd_arbiter
  import tc_hdd_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_write,
  input  logic [1:0][63:0] req_addr,
  input  logic [1:0][63:0] req_wdata,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic [1:0]       rsp_err,
  output logic [1:0][63:0] rsp_rdata,
  output logic [63:0]      hdd_seek,
  output logic             hdd_load,
  output logic             hdd_save,
  output logic [63:0]      hdd_in,
  input  logic [63:0]      hdd_out
);

  localparam logic [63:0] DEPTH_W = 64'(DEPTH);

  state_t      state_q, state_d;
  txn_t        txn_q;
  logic [63:0] pos_q;
  logic        prio_q;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_port;
  logic [63:0] acc_addr;

  tc_rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio_q),
    .grant (grant)
  );

  // grant is a subset of req_valid, so any grant in IDLE is a handshake
  assign accept   = (state_q == IDLE) && (grant != 2'b00);
  assign acc_port = grant[1];
  assign acc_addr = req_addr[acc_port];

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_err   = 2'b00;
    rsp_rdata = '0;
    hdd_seek  = '0;
    hdd_load  = 1'b0;
    hdd_save  = 1'b0;
    hdd_in    = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (accept) begin
          if (acc_addr >= DEPTH_W) begin
            state_d = RESP;
          end else if (acc_addr == pos_q) begin
            state_d = ACCESS;
          end else begin
            state_d = SEEK;
          end
        end
      end
      SEEK: begin
        hdd_seek = txn_q.addr - pos_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        hdd_load = !txn_q.write;
        hdd_save = txn_q.write;
        hdd_in   = txn_q.wdata;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[txn_q.port] = 1'b1;
        rsp_err[txn_q.port]   = txn_q.err;
        if (!txn_q.write && !txn_q.err) begin
          rsp_rdata[txn_q.port] = hdd_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      prio_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        txn_q.port  <= acc_port;
        txn_q.write <= req_write[acc_port];
        txn_q.err   <= (acc_addr >= DEPTH_W);
        txn_q.addr  <= acc_addr;
        txn_q.wdata <= req_wdata[acc_port];
        prio_q      <= ~acc_port;
      end
      // pos mirrors the Hdd head, which applies hdd_seek on this same edge
      if (state_q == SEEK) begin
        pos_q <= txn_q.addr;
      end
    end
  end

endmodule

// File: tb/tb_tc_hdd_arbiter.sv
// Bench for tc_hdd_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_tc_hdd_arbiter;

  localparam int DEPTH = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_write, req_ready, rsp_valid, rsp_err;
  logic [1:0][63:0] req_addr, req_wdata, rsp_rdata;
  logic [63:0]      hdd_seek, hdd_in, hdd_out;
  logic             hdd_load, hdd_save;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tc_hdd_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hdd_seek(hdd_seek), .hdd_load(hdd_load), .hdd_save(hdd_save),
    .hdd_in(hdd_in), .hdd_out(hdd_out)
  );

  // Attached Hdd: relative head moves, load/save at the head, shares the reset
  logic [63:0] hmem [0:DEPTH-1];
  logic [63:0] hdd_mp;
  initial for (int i = 0; i < DEPTH; i++) hmem[i] = '0;
  always @(posedge clk) begin
    if (rst) begin
      hdd_mp  <= '0;
      hdd_out <= '0;
    end else begin
      hdd_mp <= hdd_mp + hdd_seek;
      if (hdd_save) hmem[hdd_mp[7:0]] <= hdd_in;
      if (hdd_load) hdd_out <= hmem[hdd_mp[7:0]];
    end
  end

  // Transaction-level reference
  logic [63:0] ref_mem [0:DEPTH-1];
  logic [63:0] ref_pos;
  int          ref_prio;
  int          exp_port, exp_lat;
  logic [63:0] exp_seek, exp_rdata;
  logic        exp_err;

  function automatic int ref_winner(input logic [1:0] v);
    if (v == 2'b11) return ref_prio;
    return v[1] ? 1 : 0;
  endfunction

  task automatic ref_reset();
    ref_pos  = '0;
    ref_prio = 0;
  endtask

  task automatic model_accept(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    exp_port  = p;
    exp_err   = (a >= 64'(DEPTH));
    exp_lat   = exp_err ? 1 : ((a == ref_pos) ? 2 : 3);
    exp_seek  = exp_err ? 64'd0 : a - ref_pos;
    exp_rdata = (exp_err || w) ? 64'd0 : ref_mem[a[7:0]];
    if (!exp_err) begin
      if (w) ref_mem[a[7:0]] = d;
      ref_pos = a;
    end
    ref_prio = 1 - p;
  endtask

  // Observations of one transaction
  int          ob_port, ob_lat, ob_seek_cycles, ob_access;
  logic [63:0] ob_seek, ob_hin, ob_rdata;
  logic        ob_ld, ob_sv, ob_err, ob_stray, ob_busy_rdy, ob_timeout;

  task automatic clear_req();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    req_valid[p] = 1'b1; req_write[p] = w; req_addr[p] = a; req_wdata[p] = d;
  endtask

  // Waits for a handshake, then follows the transaction to its response cycle (returns mid-RESP).
  task automatic run_txn(input bit drop);
    int guard;
    logic [1:0] own;
    ob_port = -1; ob_lat = 0; ob_seek_cycles = 0; ob_access = 0;
    ob_seek = '0; ob_hin = '0; ob_rdata = '0;
    ob_ld = 0; ob_sv = 0; ob_err = 0; ob_stray = 0; ob_busy_rdy = 0; ob_timeout = 0;
    guard = 0;
    forever begin
      #1;
      if ((req_valid & req_ready) != 2'b00 || guard >= 20) break;
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin ob_timeout = 1; return; end
    ob_port = req_ready[1] ? 1 : 0;
    if (req_ready == 2'b11) ob_stray = 1;
    own = (ob_port == 1) ? 2'b10 : 2'b01;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) ob_busy_rdy = 1;
      if (hdd_seek != 0) begin ob_seek = hdd_seek; ob_seek_cycles++; end
      if (hdd_load || hdd_save) begin
        ob_ld |= hdd_load; ob_sv |= hdd_save; ob_hin = hdd_in; ob_access++;
      end
      if (n == 1 && drop) req_valid[ob_port] = 1'b0;
      if (rsp_valid != 2'b00) begin
        ob_lat   = n;
        ob_rdata = rsp_rdata[ob_port];
        ob_err   = rsp_err[ob_port];
        if (rsp_valid != own || (rsp_err & ~own) != 2'b00 || rsp_rdata[1-ob_port] != 0) ob_stray = 1;
        break;
      end
    end
    if (ob_lat == 0) ob_timeout = 1;
  endtask

  task automatic test_reset();
    clear_req();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({rsp_valid, rsp_err, req_ready} !== 6'b0) begin miscompares++;
      $display("FAIL reset_ctrl got %b want 0", {rsp_valid, rsp_err, req_ready}); end
    vectors++; if ({hdd_seek, hdd_in, rsp_rdata, hdd_load, hdd_save} !== '0) begin miscompares++;
      $display("FAIL reset_data got nonzero want all 0"); end
    vectors++; if (hdd_mp !== 64'd0) begin miscompares++;
      $display("FAIL reset_pos got %0d want 0", hdd_mp); end
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++;
      $display("FAIL reset_prio got %b want 01", req_ready); end
    clear_req();
  endtask

  task automatic test_write_seek();
    set_req(0, 1'b1, 64'd5, 64'hDEAD);
    model_accept(0, 1'b1, 64'd5, 64'hDEAD);
    run_txn(1);
    vectors++; if (ob_timeout || ob_port !== 0) begin miscompares++;
      $display("FAIL w5_port got %0d want 0", ob_port); end
    vectors++; if (ob_seek !== 64'd5 || ob_seek_cycles !== 1) begin miscompares++;
      $display("FAIL w5_seek got %0h x%0d want 5 x1", ob_seek, ob_seek_cycles); end
    vectors++; if (ob_sv !== 1'b1 || ob_ld !== 1'b0 || ob_hin !== 64'hDEAD) begin miscompares++;
      $display("FAIL w5_access got sv=%b ld=%b in=%0h want sv=1 ld=0 in=dead", ob_sv, ob_ld, ob_hin); end
    vectors++; if (ob_lat !== 3 || ob_rdata !== 64'd0 || ob_stray) begin miscompares++;
      $display("FAIL w5_rsp got lat=%0d rdata=%0h stray=%b want lat=3 rdata=0", ob_lat, ob_rdata, ob_stray); end
    clear_req();
  endtask

  task automatic test_read_noseek();
    set_req(0, 1'b0, 64'd5, 64'h0);
    model_accept(0, 1'b0, 64'd5, 64'h0);
    run_txn(1);
    vectors++; if (ob_seek_cycles !== 0 || ob_ld !== 1'b1 || ob_sv !== 1'b0) begin miscompares++;
      $display("FAIL r5_access got seeks=%0d ld=%b sv=%b want 0 1 0", ob_seek_cycles, ob_ld, ob_sv); end
    vectors++; if (ob_timeout || ob_lat !== 2 || ob_rdata !== 64'hDEAD) begin miscompares++;
      $display("FAIL r5_rsp got lat=%0d rdata=%0h want lat=2 rdata=dead", ob_lat, ob_rdata); end
    clear_req();
  endtask

  task automatic test_neg_seek();
    set_req(1, 1'b0, 64'd2, 64'h0);
    model_accept(1, 1'b0, 64'd2, 64'h0);
    run_txn(1);
    vectors++; if (ob_seek !== 64'hFFFF_FFFF_FFFF_FFFD) begin miscompares++;
      $display("FAIL r2_seek got %0h want fffffffffffffffd", ob_seek); end
    vectors++; if (hdd_mp !== 64'd2 || ob_port !== 1 || ob_lat !== 3) begin miscompares++;
      $display("FAIL r2_pos got pos=%0d port=%0d lat=%0d want 2 1 3", hdd_mp, ob_port, ob_lat); end
    clear_req();
  endtask

  task automatic test_error();
    set_req(1, 1'b0, 64'd256, 64'h0);
    model_accept(1, 1'b0, 64'd256, 64'h0);
    run_txn(1);
    vectors++; if (ob_timeout || ob_lat !== 1 || ob_err !== 1'b1 || ob_rdata !== 64'd0) begin miscompares++;
      $display("FAIL err_rsp got lat=%0d err=%b rdata=%0h want 1 1 0", ob_lat, ob_err, ob_rdata); end
    vectors++; if (ob_access !== 0 || ob_seek_cycles !== 0) begin miscompares++;
      $display("FAIL err_noaccess got acc=%0d seeks=%0d want 0 0", ob_access, ob_seek_cycles); end
    @(negedge clk);
    vectors++; if (hdd_mp !== 64'd2) begin miscompares++;
      $display("FAIL err_pos got %0d want 2", hdd_mp); end
    clear_req();
  endtask

  task automatic test_round_robin();
    int want [4] = '{0, 1, 0, 1};
    test_reset();
    set_req(0, 1'b1, 64'd3, 64'h1111);
    set_req(1, 1'b0, 64'd3, 64'h0);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = ref_winner(req_valid);
      model_accept(w, req_write[w], req_addr[w], req_wdata[w]);
      run_txn(0);
      vectors++; if (ob_timeout || ob_port !== want[k] || ob_stray) begin miscompares++;
        $display("FAIL rr_grant%0d got port=%0d stray=%b want %0d", k, ob_port, ob_stray, want[k]); end
      vectors++; if (ob_lat !== exp_lat || ob_rdata !== exp_rdata) begin miscompares++;
        $display("FAIL rr_rsp%0d got lat=%0d rdata=%0h want %0d %0h", k, ob_lat, ob_rdata, exp_lat, exp_rdata); end
    end
    clear_req();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    set_req(0, 1'b1, 64'd9, 64'hBEEF);
    #1;
    while (req_ready[0] !== 1'b1 && guard < 20) begin @(negedge clk); #1; guard++; end
    @(posedge clk);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    vectors++; if (hdd_save !== 1'b1) begin miscompares++;
      $display("FAIL mid_access got save=%b want 1", hdd_save); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_reset();
    vectors++; if (hdd_mp !== 64'd0 || {hdd_load, hdd_save} !== 2'b00) begin miscompares++;
      $display("FAIL mid_pos got pos=%0d ld/sv=%b want 0 00", hdd_mp, {hdd_load, hdd_save}); end
    begin
      logic seen = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid != 2'b00) seen = 1; end
      vectors++; if (seen !== 1'b0) begin miscompares++;
        $display("FAIL mid_norsp got rsp seen want none"); end
    end
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++;
      $display("FAIL mid_idle got ready=%b want 01", req_ready); end
    clear_req();
    set_req(0, 1'b0, 64'd0, 64'h0);
    model_accept(0, 1'b0, 64'd0, 64'h0);
    run_txn(1);
    vectors++; if (ob_timeout || ob_seek_cycles !== 0 || ob_lat !== 2 || ob_rdata !== exp_rdata) begin miscompares++;
      $display("FAIL mid_read0 got seeks=%0d lat=%0d rdata=%0h want 0 2 %0h", ob_seek_cycles, ob_lat, ob_rdata, exp_rdata); end
    clear_req();
  endtask

  task automatic test_random();
    bit          pv [2];
    logic        pw [2];
    logic [63:0] pa [2], pd [2];
    pv[0] = 0; pv[1] = 0;
    for (int k = 0; k < 60; k++) begin
      int w;
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 1) == 1) begin
          pv[p] = 1;
          pw[p] = 1'($urandom_range(0, 1));
          pa[p] = ($urandom_range(0, 9) == 0) ? 64'(DEPTH + $urandom_range(0, 3))
                                              : 64'($urandom_range(0, 15));
          pd[p] = {$urandom, $urandom};
        end
      end
      if (!pv[0] && !pv[1]) begin
        pv[0] = 1; pw[0] = 1'b1; pa[0] = 64'($urandom_range(0, 15)); pd[0] = {$urandom, $urandom};
      end
      clear_req();
      for (int p = 0; p < 2; p++) if (pv[p]) set_req(p, pw[p], pa[p], pd[p]);
      w = ref_winner(req_valid);
      model_accept(w, pw[w], pa[w], pd[w]);
      run_txn(1);
      pv[w] = 0;
      vectors++; if (ob_timeout || ob_port !== exp_port || ob_stray || ob_busy_rdy) begin miscompares++;
        $display("FAIL rnd%0d_port got %0d stray=%b busyrdy=%b want %0d", k, ob_port, ob_stray, ob_busy_rdy, exp_port); end
      vectors++; if (ob_lat !== exp_lat || ob_err !== exp_err || ob_rdata !== exp_rdata) begin miscompares++;
        $display("FAIL rnd%0d_rsp got lat=%0d err=%b rdata=%0h want %0d %b %0h", k, ob_lat, ob_err, ob_rdata, exp_lat, exp_err, exp_rdata); end
      vectors++; if (ob_seek_cycles !== ((exp_lat == 3) ? 1 : 0) || ob_seek !== ((exp_lat == 3) ? exp_seek : 64'd0)) begin miscompares++;
        $display("FAIL rnd%0d_seek got %0h x%0d want %0h", k, ob_seek, ob_seek_cycles, exp_seek); end
      vectors++; if (ob_ld !== (!exp_err && !pw[w]) || ob_sv !== (!exp_err && pw[w]) || (!exp_err && ob_hin !== pd[w])) begin miscompares++;
        $display("FAIL rnd%0d_access got ld=%b sv=%b in=%0h", k, ob_ld, ob_sv, ob_hin); end
      vectors++; if (hdd_mp !== ref_pos) begin miscompares++;
        $display("FAIL rnd%0d_pos got %0d want %0d", k, hdd_mp, ref_pos); end
    end
    clear_req();
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_reset();
    test_reset();
    test_write_seek();
    test_read_noseek();
    test_neg_seek();
    test_error();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
